// File: rtl/disp_pkg.sv
// disp_pkg: shared states, limits and round-robin helpers for the display scheduler
package disp_pkg;
  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;
  localparam int MAX_DISPLAY = 9999;
  localparam int BCD_DIGITS = 4;
  // Rotate so the requester after `last` is checked first, pick the lowest set bit, rotate back.
  function automatic logic [2:0] rr_pick(input logic [2:0] mask, input logic [1:0] last);
    logic [2:0] r;
    logic [2:0] p;
    r = last == 2'd0 ? {mask[0], mask[2], mask[1]} : last == 2'd1 ? {mask[1], mask[0], mask[2]} : mask;
    p = r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
    return last == 2'd0 ? {p[1], p[0], p[2]} : last == 2'd1 ? {p[0], p[2], p[1]} : p;
  endfunction
  function automatic logic [1:0] oh2idx(input logic [2:0] oh);
    return oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-add-3 binary to BCD, one input bit per cycle
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int VALUE_W = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [VALUE_W-1:0]      din,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] result
);
  localparam int CW = $clog2(VALUE_W + 1);
  logic [VALUE_W-1:0] sh;
  logic [4*BCD_DIGITS-1:0] acc;
  logic [4*BCD_DIGITS-1:0] adj;
  logic [CW-1:0] cnt;
  logic active;
  always_comb begin
    adj = acc;
    for (int i = 0; i < BCD_DIGITS; i++)
      adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end
  // result is the post-step value, so the caller can capture it on the edge done is high
  assign result = {adj[4*BCD_DIGITS-2:0], sh[VALUE_W-1]};
  assign done = active && cnt == CW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
      acc <= '0;
      cnt <= '0;
      active <= 1'b0;
    end else if (start) begin
      sh <= din;
      acc <= '0;
      cnt <= CW'(VALUE_W);
      active <= 1'b1;
    end else if (active) begin
      sh <= sh << 1;
      acc <= result;
      cnt <= cnt - 1'b1;
      active <= cnt != CW'(1);
    end
  end
endmodule

// File: rtl/disp_scheduler.sv
// disp_scheduler: round-robin owner of a 4-digit BCD display with timed dwell and refresh
module disp_scheduler
  import disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 100000000,
  parameter int VALUE_W = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         req,
  input  logic [VALUE_W-1:0] value0,
  input  logic [VALUE_W-1:0] value1,
  input  logic [VALUE_W-1:0] value2,
  output logic [2:0]         grant,
  output logic [15:0]        bcd,
  output logic               bcd_valid,
  output logic               busy
);
  localparam int DW = $clog2(DWELL_CYCLES);
  state_t state, state_nx;
  logic [2:0] grant_nx, pick, others;
  logic [1:0] last;
  logic [DW-1:0] dcnt;
  logic owner_pending, expire, latch_new, refresh, start, conv_done;
  logic [VALUE_W-1:0] sel, din;
  logic [15:0] conv_bcd;
  assign others = req & ~grant;
  assign owner_pending = |(req & grant);
  assign pick = rr_pick(others, last);
  assign expire = state == SHOW && (dcnt == DW'(DWELL_CYCLES - 1) || !owner_pending);
  assign latch_new = |others && (state == IDLE || expire);
  assign refresh = expire && !(|others) && owner_pending;
  assign start = latch_new || refresh;
  assign sel = grant_nx[0] ? value0 : grant_nx[1] ? value1 : value2;
  assign din = 32'(sel) > 32'(MAX_DISPLAY) ? VALUE_W'(MAX_DISPLAY) : sel;
  assign busy = state == CONV;
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    if (start) begin
      state_nx = CONV;
      grant_nx = latch_new ? pick : grant;
    end else if (state == CONV && conv_done) begin
      state_nx = SHOW;
    end else if (expire) begin
      state_nx = IDLE;
      grant_nx = '0;
    end
  end
  // last resets to requester 2 so requester 0 wins the first arbitration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      last <= 2'd2;
      bcd <= '0;
      bcd_valid <= 1'b0;
      dcnt <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      if (start) last <= oh2idx(grant_nx);
      if (state == CONV && conv_done) begin
        bcd <= conv_bcd;
        bcd_valid <= 1'b1;
      end
      dcnt <= state == SHOW && !expire ? dcnt + 1'b1 : '0;
    end
  end
  bin2bcd_seq #(.VALUE_W(VALUE_W)) u_conv (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .din(din),
    .done(conv_done),
    .result(conv_bcd)
  );
endmodule

// File: tb/tb_disp_scheduler.sv
// tb_disp_scheduler: directed checks of arbitration, conversion timing, dwell and reset
module tb_disp_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [13:0] value0 = '0, value1 = '0, value2 = '0;
  logic [2:0] grant;
  logic [15:0] bcd;
  logic bcd_valid, busy;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  disp_scheduler #(.DWELL_CYCLES(8), .VALUE_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .value0(value0), .value1(value1), .value2(value2),
    .grant(grant), .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = 3'b111;
    @(negedge clk);
    n_tests++;
    if ({grant, bcd, bcd_valid, busy} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_hold: grant=%b bcd=%h valid=%b busy=%b, want all 0", grant, bcd, bcd_valid, busy);
    end
    req = '0;
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (grant !== 3'b000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: grant=%b busy=%b, want 000/0", grant, busy);
    end
  endtask

  task automatic test_single;
    logic bad;
    value0 = 14'd1234;
    req = 3'b001;
    tick();
    n_tests++;
    if (grant !== 3'b001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b busy=%b, want 001/1", grant, busy);
    end
    bad = 1'b0;
    repeat (13) begin
      tick();
      if (bcd !== 16'h0000 || bcd_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL single_conv_hold: bcd=%h valid=%b busy=%b, want 0000/0/1 for G..G+13", bcd, bcd_valid, busy);
    end
    tick();
    n_tests++;
    if (bcd !== 16'h1234 || bcd_valid !== 1'b1 || busy !== 1'b0 || grant !== 3'b001) begin
      n_fail++;
      $display("FAIL single_result: bcd=%h valid=%b busy=%b grant=%b, want 1234/1/0/001", bcd, bcd_valid, busy, grant);
    end
    bad = 1'b0;
    repeat (7) begin
      tick();
      if (bcd !== 16'h1234 || busy !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL single_dwell: bcd=%h busy=%b, want 1234/0 through G+21", bcd, busy);
    end
    tick();
    n_tests++;
    if (busy !== 1'b1 || grant !== 3'b001 || bcd !== 16'h1234) begin
      n_fail++;
      $display("FAIL single_refresh_start: busy=%b grant=%b bcd=%h, want 1/001/1234", busy, grant, bcd);
    end
    value0 = 14'd5678;
    bad = 1'b0;
    repeat (13) begin
      tick();
      if (bcd !== 16'h1234 || bcd_valid !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL refresh_no_glitch: bcd=%h valid=%b, want 1234/1", bcd, bcd_valid);
    end
    tick();
    n_tests++;
    if (bcd !== 16'h1234 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL refresh_sample: bcd=%h busy=%b, want 1234/0 (value change ignored)", bcd, busy);
    end
    req = '0;
    tick();
    n_tests++;
    if (grant !== 3'b000 || busy !== 1'b0 || bcd !== 16'h1234 || bcd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL release_idle: grant=%b busy=%b bcd=%h valid=%b, want 000/0/1234/1", grant, busy, bcd, bcd_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0] eg [4];
    logic [15:0] eb [4];
    eg = '{3'b001, 3'b010, 3'b100, 3'b001};
    eb = '{16'h0001, 16'h0002, 16'h0003, 16'h0001};
    do_reset();
    value0 = 14'd1;
    value1 = 14'd2;
    value2 = 14'd3;
    req = 3'b111;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (grant !== eg[k] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: grant=%b busy=%b, want %b/1", k, grant, busy, eg[k]);
      end
      repeat (14) tick();
      n_tests++;
      if (bcd !== eb[k] || bcd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_bcd[%0d]: bcd=%h valid=%b, want %h/1", k, bcd, bcd_valid, eb[k]);
      end
      repeat (7) tick();
      n_tests++;
      if (grant !== eg[k] || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_dwell_end[%0d]: grant=%b busy=%b, want %b/0", k, grant, busy, eg[k]);
      end
      tick();
    end
    n_tests++;
    if (grant !== 3'b010) begin
      n_fail++;
      $display("FAIL rr_wrap: grant=%b, want 010", grant);
    end
    req = '0;
  endtask

  task automatic test_saturate_and_zero;
    do_reset();
    value1 = 14'd12000;
    req = 3'b010;
    tick();
    n_tests++;
    if (grant !== 3'b010) begin
      n_fail++;
      $display("FAIL sat_grant: grant=%b, want 010", grant);
    end
    repeat (14) tick();
    n_tests++;
    if (bcd !== 16'h9999 || bcd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate: bcd=%h valid=%b, want 9999/1", bcd, bcd_valid);
    end
    value2 = 14'd0;
    req = 3'b100;
    tick();
    n_tests++;
    if (grant !== 3'b100 || busy !== 1'b1 || bcd !== 16'h9999) begin
      n_fail++;
      $display("FAIL zero_switch: grant=%b busy=%b bcd=%h, want 100/1/9999", grant, busy, bcd);
    end
    repeat (14) tick();
    n_tests++;
    if (bcd !== 16'h0000 || bcd_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_value: bcd=%h valid=%b busy=%b, want 0000/1/0", bcd, bcd_valid, busy);
    end
  endtask

  task automatic test_owner_drop;
    do_reset();
    value1 = 14'd42;
    req = 3'b010;
    tick();
    repeat (16) tick();
    n_tests++;
    if (grant !== 3'b010 || busy !== 1'b0 || bcd !== 16'h0042) begin
      n_fail++;
      $display("FAIL drop_show3: grant=%b busy=%b bcd=%h, want 010/0/0042", grant, busy, bcd);
    end
    value0 = 14'd77;
    req = 3'b001;
    tick();
    n_tests++;
    if (grant !== 3'b001 || busy !== 1'b1 || bcd !== 16'h0042) begin
      n_fail++;
      $display("FAIL drop_regrant: grant=%b busy=%b bcd=%h, want 001/1/0042", grant, busy, bcd);
    end
    repeat (14) tick();
    n_tests++;
    if (bcd !== 16'h0077) begin
      n_fail++;
      $display("FAIL drop_result: bcd=%h, want 0077", bcd);
    end
  endtask

  task automatic test_reset_midconv;
    value0 = 14'd555;
    repeat (8) tick();
    n_tests++;
    if (busy !== 1'b1 || grant !== 3'b001 || bcd !== 16'h0077) begin
      n_fail++;
      $display("FAIL midconv_refresh: busy=%b grant=%b bcd=%h, want 1/001/0077", busy, grant, bcd);
    end
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({grant, bcd, bcd_valid, busy} !== 21'd0) begin
      n_fail++;
      $display("FAIL midconv_async: grant=%b bcd=%h valid=%b busy=%b, want all 0", grant, bcd, bcd_valid, busy);
    end
    req = 3'b010;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (grant !== 3'b010 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_grant: grant=%b busy=%b, want 010/1", grant, busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_saturate_and_zero();
    test_owner_drop();
    test_reset_midconv();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/disp_scheduler.md
DISP_SCHEDULER -- requirements
Module: disp_scheduler

Interface
REQ-001 Parameter: DWELL_CYCLES, 100000000, number of clk cycles a granted value is shown; legal values are 2 or more.
REQ-002 Parameter: VALUE_W, 14, width of each requester's binary value.
REQ-003 Port: clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req  input  3  per-requester display request; bit i belongs to requester i.
REQ-006 Port: value0, value1, value2  input  VALUE_W each  unsigned binary value of requester 0/1/2.
REQ-007 Port: grant  output  3  one-hot owner of the display; all zeros means no owner.
REQ-008 Port: bcd  output  16  four BCD digits; thousands in [15:12] down to units in [3:0]; drives the four-digit 7-segment mux.
REQ-009 Port: bcd_valid  output  1  bcd holds a completed conversion.
REQ-010 Port: busy  output  1  high while in CONV.

Function
REQ-011 The state machine SHALL have three states: IDLE, CONV and SHOW.
REQ-012 IDLE: with any req bit high, the block SHALL select one requester round-robin, starting from the requester after last_grant, latch its value, set grant one-hot, and enter CONV on the same edge.
REQ-013 Saturation: a latched value above 9999 SHALL be replaced by 9999 before conversion.
REQ-014 CONV: the block SHALL run an iterative shift-add-3 binary-to-BCD conversion, one bit per cycle, for exactly VALUE_W cycles.
REQ-015 Cycle timing: the first cycle with grant high is cycle G; CONV occupies G..G+13; bcd, bcd_valid=1 and the move to SHOW SHALL become visible at G+14.
REQ-016 During CONV, bcd SHALL keep its previous contents, with no intermediate partial values.
REQ-017 SHOW: a dwell counter SHALL run for exactly DWELL_CYCLES cycles, G+14 through G+13+DWELL_CYCLES.
REQ-018 Dwell expiry with another requester pending: the block SHALL re-arbitrate round-robin, excluding the current owner, and go to CONV with grant switched on that same edge.
REQ-019 Dwell expiry with only the current owner pending: the block SHALL re-latch its current value and reconvert (refresh); grant stays high; bcd and bcd_valid hold the old digits until the new ones are ready.
REQ-020 Dwell expiry with no req: the block SHALL go to IDLE, clear grant and hold bcd and bcd_valid.
REQ-021 If the owner drops req during SHOW, the dwell SHALL end on the next edge and REQ-018 or REQ-020 then applies.
REQ-022 If the owner drops req during CONV, the conversion SHALL still complete and SHOW SHALL then end one cycle later per REQ-021.
REQ-023 The value inputs SHALL be sampled only on latch edges; changes at any other time have no effect.
REQ-024 last_grant SHALL update on every latch; grant SHALL never have more than one bit set.
REQ-025 The dwell counter SHALL be sized to $clog2(DWELL_CYCLES) bits and SHALL not wrap within a dwell.

Reset
REQ-026 While rst_n is low, the block SHALL hold: state IDLE, grant 0, bcd 16'h0000, bcd_valid 0, busy 0, dwell counter 0, and last_grant set so that requester 0 wins first.
REQ-027 Reset asserted mid-CONV or mid-SHOW SHALL abort immediately, asynchronously; the first arbitration after release follows REQ-012.

Structure
REQ-028 Shared package disp_pkg SHALL hold the state enum, MAX_DISPLAY=9999 and BCD_DIGITS=4.
REQ-029 The design SHALL contain one sub-module, bin2bcd_seq (start/done handshake, VALUE_W-cycle shift-add-3), instantiated once.
REQ-030 The design SHALL contain no combinational divide or modulo operators.

Verification (benches run with DWELL_CYCLES=8)
REQ-031 req=001, value0=1234, held -> grant=001 at G; bcd=16'h1234 and bcd_valid=1 at G+14; bcd held 8 cycles; refresh starts at G+22 with no glitch on bcd.
REQ-032 req=111 right after reset, values 1/2/3 -> grant sequence 001,010,100,001; each dwell is exactly 8 cycles; bcd shows 0001, 0002, 0003.
REQ-033 value1=12000, req=010 -> bcd=16'h9999.
REQ-034 value2=0, req=100 -> bcd=16'h0000 with bcd_valid=1, distinct from the reset state.
REQ-035 Owner drops req at SHOW cycle 3 with req0 pending -> grant moves to 001 on the next edge; CONV restarts.
REQ-036 rst_n pulsed low at CONV cycle 5 -> grant, bcd, bcd_valid and busy all 0 immediately; after release with req=010, grant=010 on the first edge.
